shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
- Multi-cycle shift/rotate sequencer that sits directly upstream of the model CPU's combinational shifter.
- Holds the working operand register and drives the shifter's operand and its fbus/flbus/frbus select strobes.
- Captures the shifter result and carry back each cycle, so an N-position rotate takes N passes through the shifter.
- Presents the final word and carry to the CPU datapath with a start/busy/done handshake.

Parameters:
- WIDTH, 8, data width; matches the shifter.
- CNT_W, 3, width of the shift-amount field (0..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dir  input  1  0 = rotate right (frbus), 1 = rotate left (flbus).
- cnt  input  CNT_W  number of positions to shift.
- din  input  WIDTH  operand, latched on accepted start.
- w  input  WIDTH  result from shifter.
- cf_in  input  1  carry from shifter.
- a  output  WIDTH  operand to shifter; equals working register.
- fbus  output  1  pass-through select to shifter.
- frbus  output  1  rotate-right select to shifter.
- flbus  output  1  rotate-left select to shifter.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; dout/cf valid.
- dout  output  WIDTH  result; equals working register.
- cf  output  1  carry flag register.

Behaviour:
- Clock and reset: one clock domain. rst_n low forces IDLE, working register=0, remaining count=0, cf=0, done=0, all strobes 0. This holds at any time, including mid-operation; no partial result is retained.
- States are IDLE, PASS, SHIFT and DONE.
- IDLE:
  - start=1 latches din, dir and cnt.
  - Next state is PASS if cnt==0, else SHIFT.
  - start while busy=1 is ignored and not queued.
- PASS (one cycle):
  - fbus=1.
  - Working register <= w; cf <= 0.
  - Next state DONE.
- SHIFT:
  - frbus=1 if dir=0, flbus=1 if dir=1.
  - Each cycle: working register <= w; cf <= cf_in; remaining <= remaining-1.
  - When remaining==1, next state DONE.
- DONE (one cycle):
  - done=1, no strobes.
  - Next state IDLE. start is not accepted in DONE; it is accepted from the following cycle.
- Strobe rules: strobes are decoded combinationally from the registered state. At most one strobe is high in any cycle; all are 0 in IDLE and DONE, so the shifter output floats (Z) there.
- Latency: start is sampled at edge E0, and done is high from edge E(n) to E(n+1), where n = max(cnt,1). Throughput is one operation per n+2 cycles.
- cf semantics:
  - Holds the last bit rotated out.
  - Holds its value between operations.
  - Cleared by a cnt==0 pass.
- cnt wrap: cnt=0 is a pure pass, never a full 2^CNT_W rotate.
- dout is stable from DONE until the next accepted start.

Optional Feature:
- Macro: SHIFT_SEQ_ARITH_EN.
- When defined:
  - Adds input port arith (1 bit), latched with start.
  - With arith=1 and dir=0, each SHIFT cycle loads {working[WIDTH-1], w[WIDTH-2:0]}, giving an arithmetic right shift.
  - With arith=1 and dir=1, each SHIFT cycle loads {w[WIDTH-1:1], 1'b0}, giving a logical left shift.
  - cf is still cf_in in both cases.
- When not defined: the arith port is absent and the block does only pure rotates.

Decomposition:
- Shared CPU package holds:
  - the state encoding (IDLE, PASS, SHIFT, DONE);
  - direction constants DIR_R=0 and DIR_L=1;
  - the WIDTH default.
- One sub-module, shift_seq_ctr: the down-counter that loads cnt and flags remaining==1.
- The datapath register and FSM stay in shift_seq.

Test Plan:
- The bench instantiates a behavioural shifter model (combinational rotate with carry) wired to a/w/cf_in and the three strobes.
- Rotate right by 1: din=8'hB4, dir=0, cnt=1 -> frbus for 1 cycle; done after 1 cycle; dout=8'h5A, cf=0.
- Rotate right by 3: din=8'hB4, dir=0, cnt=3 -> frbus for 3 cycles; dout=8'h96, cf=1; busy high for 4 cycles.
- Rotate left by 1: din=8'h81, dir=1, cnt=1 -> flbus for 1 cycle; dout=8'h03, cf=1.
- Pass-through: preload cf=1, then din=8'h3C, cnt=0 -> fbus for 1 cycle; dout=8'h3C, cf=0, done at edge 1.
- Reset mid-operation and start while busy:
  - Pulse start again during a cnt=5 operation -> no effect, exactly 5 strobe cycles.
  - Assert rst_n=0 mid-operation -> immediately busy=0, all strobes 0, dout=0, cf=0.
- With SHIFT_SEQ_ARITH_EN defined:
  - din=8'h80, dir=0, arith=1, cnt=2 -> dout=8'hE0, cf=0.
  - din=8'h81, dir=1, arith=1, cnt=1 -> dout=8'h02, cf=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared definitions for the shift/rotate sequencer.
//   - FSM state encoding (IDLE, PASS, SHIFT, DONE)
//   - rotate direction constants (DIR_R, DIR_L)
//   - default data and count widths
package shift_seq_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PASS  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/shift_seq_ctr.sv
// shift_seq_ctr: remaining-positions down-counter for shift_seq.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_load      load i_cnt into the counter
//   i_dec       decrement by one (ignored while i_load is high)
//   i_cnt       shift amount to load
//   o_last      remaining == 1, i.e. the current SHIFT cycle is the final one
module shift_seq_ctr #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_cnt;
        end else if (i_dec) begin
            r_rem <= r_rem - 1'b1;
        end
    end

    assign o_last = (r_rem == CNT_W'(1));

endmodule

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift/rotate sequencer driving an external combinational shifter.
// The working register is sent to the shifter on o_a, and the shifter result (i_w, i_cf_in)
// is reloaded once per cycle, so an N-position rotate takes N passes.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   i_start, i_dir, i_cnt   request, direction (0 right, 1 left), shift amount
//   i_din                   operand, latched on accepted start
//   i_w, i_cf_in            shifter result and carry
//   o_a                     operand to shifter (working register)
//   o_fbus/o_frbus/o_flbus  pass / rotate-right / rotate-left selects
//   o_busy, o_done          handshake: busy outside IDLE, one-cycle done pulse
//   o_dout, o_cf            result word and carry flag
// Optional feature macro: SHIFT_SEQ_ARITH_EN adds i_arith (arithmetic right / logical left).
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_dir,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_din,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             i_arith,
`endif
    input  logic [WIDTH-1:0] i_w,
    input  logic             i_cf_in,
    output logic [WIDTH-1:0] o_a,
    output logic             o_fbus,
    output logic             o_frbus,
    output logic             o_flbus,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_cf
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic             r_cf;
    logic             r_dir;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_ctr_load;
    logic             w_ctr_dec;
    logic             w_last;

`ifdef SHIFT_SEQ_ARITH_EN
    logic r_arith;
`endif

    shift_seq_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_ctr_load),
        .i_dec  (w_ctr_dec),
        .i_cnt  (i_cnt),
        .o_last (w_last)
    );

    // Value loaded into the working register on a SHIFT cycle.
    always_comb begin
        w_shift_val = i_w;
`ifdef SHIFT_SEQ_ARITH_EN
        if (r_arith) begin
            if (r_dir == DIR_R) begin
                // Replace the rotated-in MSB with the old sign bit.
                w_shift_val = {r_work[WIDTH-1], i_w[WIDTH-2:0]};
            end else begin
                // Replace the rotated-in LSB with zero.
                w_shift_val = {i_w[WIDTH-1:1], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_load  = 1'b0;
        w_ctr_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_ctr_load  = 1'b1;
                    // cnt == 0 is a pure pass, never a full-width rotate.
                    w_state_nxt = (i_cnt == '0) ? ST_PASS : ST_SHIFT;
                end
            end
            ST_PASS: w_state_nxt = ST_DONE;
            ST_SHIFT: begin
                w_ctr_dec = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cf    <= 1'b0;
            r_dir   <= DIR_R;
`ifdef SHIFT_SEQ_ARITH_EN
            r_arith <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_work  <= i_din;
                        r_dir   <= i_dir;
`ifdef SHIFT_SEQ_ARITH_EN
                        r_arith <= i_arith;
`endif
                    end
                end
                ST_PASS: begin
                    r_work <= i_w;
                    r_cf   <= 1'b0;
                end
                ST_SHIFT: begin
                    r_work <= w_shift_val;
                    r_cf   <= i_cf_in;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode from registered state only, so at most one is ever high.
    assign o_fbus  = (r_state == ST_PASS);
    assign o_frbus = (r_state == ST_SHIFT) && (r_dir == DIR_R);
    assign o_flbus = (r_state == ST_SHIFT) && (r_dir == DIR_L);
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_a     = r_work;
    assign o_dout  = r_work;
    assign o_cf    = r_cf;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: self-checking bench for shift_seq with a behavioural shifter in the loop.
// Directed table vectors, hand sequences for reset / busy-start corners, then random ops
// checked against an arithmetic reference model.
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic       i_dir;
    logic [2:0] i_cnt;
    logic [7:0] i_din;
    logic       i_arith;
    logic [7:0] w_shf;
    logic       cf_shf;
    logic [7:0] o_a;
    logic       o_fbus;
    logic       o_frbus;
    logic       o_flbus;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_dout;
    logic       o_cf;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq #(
        .WIDTH (8),
        .CNT_W (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (i_start),
        .i_dir   (i_dir),
        .i_cnt   (i_cnt),
        .i_din   (i_din),
`ifdef SHIFT_SEQ_ARITH_EN
        .i_arith (i_arith),
`endif
        .i_w     (w_shf),
        .i_cf_in (cf_shf),
        .o_a     (o_a),
        .o_fbus  (o_fbus),
        .o_frbus (o_frbus),
        .o_flbus (o_flbus),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_dout  (o_dout),
        .o_cf    (o_cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shifter; with no select it floats, modelled as a junk value so that a
    // stray load in the wrong state shows up.
    always_comb begin
        w_shf  = 8'hA5;
        cf_shf = 1'b1;
        if (o_fbus) begin
            w_shf  = o_a;
            cf_shf = 1'b0;
        end else if (o_frbus) begin
            w_shf  = {o_a[0], o_a[7:1]};
            cf_shf = o_a[0];
        end else if (o_flbus) begin
            w_shf  = {o_a[6:0], o_a[7]};
            cf_shf = o_a[7];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: result of shifting din by cnt positions, straight from the arithmetic.
    task automatic ref_op(input logic [7:0] din, input logic dir, input logic arith,
                          input int cnt, output logic [7:0] dout, output logic cf);
        logic [15:0] dbl;
        dbl = {din, din};
        if (cnt == 0) begin
            dout = din;
            cf   = 1'b0;
        end else if (dir == 1'b0) begin
            if (arith) dout = 8'($signed(din) >>> cnt);
            else       dout = 8'(dbl >> cnt);
            cf = din[cnt-1];
        end else begin
            if (arith) dout = 8'(din << cnt);
            else       dout = 8'((dbl << cnt) >> 8);
            cf = din[8-cnt];
        end
    endtask

    // Runs one operation and checks latency, strobes, busy, result and the DONE handshake.
    // poke_cyc > 0 pulses a junk start that many cycles into the operation.
    task automatic run_op(input string name, input logic [7:0] din, input logic dir,
                          input logic arith, input int cnt, input int poke_cyc,
                          input logic [7:0] exp_dout, input logic exp_cf);
        int   n;
        int   lat;
        int   n_strb;
        int   n_busy;
        int   n_bad;
        logic want_f;
        logic want_r;
        logic want_l;
        logic [7:0] held;
        n      = (cnt == 0) ? 1 : cnt;
        want_f = (cnt == 0);
        want_r = (cnt != 0) && !dir;
        want_l = (cnt != 0) && dir;
        lat    = 0;
        n_strb = 0;
        n_busy = 0;
        n_bad  = 0;
        @(negedge clk);
        i_din   = din;
        i_dir   = dir;
        i_arith = arith;
        i_cnt   = 3'(cnt);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (o_busy) n_busy++;
            if (o_fbus == want_f && o_frbus == want_r && o_flbus == want_l) n_strb++;
            else n_bad++;
            if (cyc == poke_cyc) begin
                i_start = 1'b1;
                i_din   = ~din;
                i_cnt   = 3'd0;
                i_dir   = ~dir;
            end
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (o_done) begin
                lat = cyc;
                break;
            end
        end
        if (lat == 0) begin
            check({name, " timeout"}, 32'(lat), 32'(n));
        end else begin
            check({name, " latency"}, 32'(lat), 32'(n));
            check({name, " strobe cycles"}, 32'(n_strb), 32'(n));
            check({name, " wrong strobes"}, 32'(n_bad), 32'd0);
            check({name, " dout"}, 32'(o_dout), 32'(exp_dout));
            check({name, " cf"}, 32'(o_cf), 32'(exp_cf));
            check({name, " done strobes"}, {29'd0, o_fbus, o_frbus, o_flbus}, 32'd0);
            n_busy += o_busy ? 1 : 0;
            check({name, " busy cycles"}, 32'(n_busy), 32'(n + 1));
            // A start during DONE must not be accepted.
            held    = o_dout;
            i_start = 1'b1;
            @(posedge clk);
            #1;
            i_start = 1'b0;
            check({name, " idle after done"}, {30'd0, o_busy, o_done}, 32'd0);
            check({name, " dout held"}, 32'(o_dout), 32'(held));
        end
    endtask

    typedef struct {
        string      name;
        logic [7:0] din;
        logic       dir;
        logic       arith;
        int         cnt;
        logic [7:0] exp_dout;
        logic       exp_cf;
    } vec_t;

    initial begin
        vec_t       vecs[$];
        logic [7:0] e_dout;
        logic       e_cf;
        logic [7:0] rd;
        logic       rdir;
        logic       rar;
        int         rc;

        vecs.push_back('{"ror1",  8'hB4, 1'b0, 1'b0, 1, 8'h5A, 1'b0});
        vecs.push_back('{"ror3",  8'hB4, 1'b0, 1'b0, 3, 8'h96, 1'b1});
        vecs.push_back('{"rol1",  8'h81, 1'b1, 1'b0, 1, 8'h03, 1'b1});
        // Follows rol1, so cf starts at 1 and the pass must clear it.
        vecs.push_back('{"pass",  8'h3C, 1'b0, 1'b0, 0, 8'h3C, 1'b0});
        vecs.push_back('{"rol7",  8'h01, 1'b1, 1'b0, 7, 8'h80, 1'b0});
        vecs.push_back('{"ror7",  8'h01, 1'b0, 1'b0, 7, 8'h02, 1'b0});
`ifdef SHIFT_SEQ_ARITH_EN
        vecs.push_back('{"asr2",  8'h80, 1'b0, 1'b1, 2, 8'hE0, 1'b0});
        vecs.push_back('{"lsl1",  8'h81, 1'b1, 1'b1, 1, 8'h02, 1'b1});
`endif

        rst_n   = 1'b0;
        i_start = 1'b0;
        i_dir   = 1'b0;
        i_cnt   = 3'd0;
        i_din   = 8'h00;
        i_arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {24'd0, o_busy, o_done, o_fbus, o_frbus, o_flbus, o_cf, 2'b00},
              32'd0);
        check("reset dout", 32'(o_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].name == "pass") check("cf held in idle", 32'(o_cf), 32'd1);
            run_op(vecs[i].name, vecs[i].din, vecs[i].dir, vecs[i].arith, vecs[i].cnt, 0,
                   vecs[i].exp_dout, vecs[i].exp_cf);
        end

        // Start pulsed while busy is neither taken nor queued.
        run_op("busy start", 8'hC3, 1'b1, 1'b0, 5, 2, 8'h78, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        i_din   = 8'hF0;
        i_dir   = 1'b0;
        i_cnt   = 3'd5;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset flags", {26'd0, o_busy, o_done, o_fbus, o_frbus, o_flbus, o_cf}, 32'd0);
        check("midreset dout", 32'(o_dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle", 32'(o_busy), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rd   = 8'($urandom);
            rdir = 1'($urandom);
            rc   = int'($urandom_range(0, 7));
`ifdef SHIFT_SEQ_ARITH_EN
            rar  = 1'($urandom);
`else
            rar  = 1'b0;
`endif
            ref_op(rd, rdir, rar, rc, e_dout, e_cf);
            run_op("random", rd, rdir, rar, rc, 0, e_dout, e_cf);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
